// File: rtl/counter_timer_n.sv
// N-channel down-counter/timer with per-channel tick enables, four counting modes,
// sticky write-1-to-clear status flags and a maskable, registered interrupt.
module counter_timer_n #(
    parameter int NCH   = 3,
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    tick,
    input  logic              counter_we,
    input  logic [3:0]        counter_ch,
    input  logic [31:0]       counter_val,
    input  logic [2:0]        counter_rd_ch,
    output logic [31:0]       counter_out,
    output logic [NCH-1:0]    counter_OUT,
    output logic [NCH-1:0]    counter_sts,
    output logic              irq
);
    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'b00,
        MODE_RATE    = 2'b01,
        MODE_SQUARE  = 2'b10,
        MODE_FREE    = 2'b11
    } mode_t;

    localparam logic [3:0]       ADDR_CLR  = 4'hE;
    localparam logic [3:0]       ADDR_CTRL = 4'hF;
    localparam logic [WIDTH-1:0] ONE       = 1;

    logic [NCH-1:0][WIDTH-1:0] cnt_all;
    logic [NCH-1:0]            ie_all;
    logic                      ctrl_wr;
    logic                      clr_wr;
    logic                      irq_reg;

    assign ctrl_wr = counter_we && (counter_ch == ADDR_CTRL);
    assign clr_wr  = counter_we && (counter_ch == ADDR_CLR);

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [WIDTH-1:0] cnt_reg, cnt_next;
        logic [WIDTH-1:0] load_reg, load_next;
        logic [3:0]       ctrl_reg, ctrl_next;
        logic             out_reg, out_next;
        logic             run_reg, run_next;
        logic             sts_reg, sts_next;
        logic             load_wr, advance, te;
        mode_t            mode, new_mode;

        assign load_wr  = counter_we && (counter_ch == 4'(gi));
        assign mode     = mode_t'(ctrl_reg[1:0]);
        assign new_mode = mode_t'(counter_val[4*gi +: 2]);
        // A load write in the same cycle swallows the tick.
        assign advance  = tick[gi] && ctrl_reg[2] && run_reg && !load_wr;
        assign te       = advance && (cnt_reg == '0);

        always_comb begin
            cnt_next  = cnt_reg;
            load_next = load_reg;
            ctrl_next = ctrl_reg;
            out_next  = out_reg;
            run_next  = run_reg;
            sts_next  = sts_reg;
            if (mode == MODE_RATE || mode == MODE_FREE) begin
                out_next = 1'b0;
            end
            if (load_wr) begin
                load_next = counter_val[WIDTH-1:0];
                cnt_next  = counter_val[WIDTH-1:0];
                out_next  = 1'b0;
                run_next  = 1'b1;
            end else if (advance) begin
                case (mode)
                    MODE_ONESHOT: begin
                        if (te) begin
                            out_next = 1'b1;
                            run_next = 1'b0;
                        end else begin
                            cnt_next = cnt_reg - ONE;
                        end
                    end
                    MODE_RATE: begin
                        if (te) begin
                            cnt_next = load_reg;
                            out_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg - ONE;
                        end
                    end
                    MODE_SQUARE: begin
                        if (te) begin
                            cnt_next = load_reg >> 1;
                            out_next = !out_reg;
                        end else begin
                            cnt_next = cnt_reg - ONE;
                        end
                    end
                    MODE_FREE: begin
                        cnt_next = cnt_reg - ONE;
                        if (te) begin
                            out_next = 1'b1;
                        end
                    end
                endcase
            end
            if (ctrl_wr) begin
                ctrl_next = counter_val[4*gi +: 4];
                if (new_mode != mode) begin
                    out_next = 1'b0;
                end
                if (new_mode == MODE_FREE) begin
                    run_next = 1'b1;
                end
            end
            if (clr_wr && counter_val[gi]) begin
                sts_next = 1'b0;
            end
            // Square wave flags only the rising half; set beats a coincident clear.
            if (te && (mode != MODE_SQUARE || !out_reg)) begin
                sts_next = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_reg  <= '0;
                load_reg <= '0;
                ctrl_reg <= '0;
                out_reg  <= 1'b0;
                run_reg  <= 1'b0;
                sts_reg  <= 1'b0;
            end else begin
                cnt_reg  <= cnt_next;
                load_reg <= load_next;
                ctrl_reg <= ctrl_next;
                out_reg  <= out_next;
                run_reg  <= run_next;
                sts_reg  <= sts_next;
            end
        end

        assign cnt_all[gi]     = cnt_reg;
        assign ie_all[gi]      = ctrl_reg[3];
        assign counter_OUT[gi] = out_reg;
        assign counter_sts[gi] = sts_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= |(counter_sts & ie_all);
        end
    end

    assign irq = irq_reg;

    always_comb begin
        counter_out = '0;
        for (int i = 0; i < NCH; i++) begin
            if (counter_rd_ch == 3'(i)) begin
                counter_out = 32'(cnt_all[i]);
            end
        end
    end
endmodule

// File: tb/tb_counter_timer_n.sv
// Directed bench for counter_timer_n (NCH=3, WIDTH=8): one task per mode/scenario,
// hand-computed expectations checked one edge at a time.
module tb_counter_timer_n;
    localparam int NCH   = 3;
    localparam int WIDTH = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NCH-1:0]  tick = '0;
    logic            counter_we = 1'b0;
    logic [3:0]      counter_ch = 4'h0;
    logic [31:0]     counter_val = 32'h0;
    logic [2:0]      counter_rd_ch = 3'd0;
    logic [31:0]     counter_out;
    logic [NCH-1:0]  counter_OUT;
    logic [NCH-1:0]  counter_sts;
    logic            irq;

    int n_checks = 0;
    int n_fail   = 0;

    counter_timer_n #(.NCH(NCH), .WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .counter_we    (counter_we),
        .counter_ch    (counter_ch),
        .counter_val   (counter_val),
        .counter_rd_ch (counter_rd_ch),
        .counter_out   (counter_out),
        .counter_OUT   (counter_OUT),
        .counter_sts   (counter_sts),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] ch, input logic [31:0] val);
        counter_we  = 1'b1;
        counter_ch  = ch;
        counter_val = val;
        step();
        counter_we  = 1'b0;
        $display("write ch=%h val=%h", ch, val);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        n_checks++; if (counter_OUT !== 3'b000) begin n_fail++; $display("FAIL reset_out: got %b expected 000", counter_OUT); end
        n_checks++; if (counter_sts !== 3'b000) begin n_fail++; $display("FAIL reset_sts: got %b expected 000", counter_sts); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
        rst = 1'b1;
        step();
        for (int r = 0; r < 8; r++) begin
            counter_rd_ch = 3'(r);
            #1;
            n_checks++; if (counter_out !== 32'h0) begin n_fail++; $display("FAIL reset_cnt rd=%0d: got %0h expected 0", r, counter_out); end
        end
        $display("reset released");
    endtask

    task automatic test_oneshot();
        counter_rd_ch = 3'd0;
        wr(4'hF, 32'h4);
        wr(4'h0, 32'd5);
        n_checks++; if (counter_out !== 32'd5) begin n_fail++; $display("FAIL oneshot_load: got %0h expected 5", counter_out); end
        tick[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            n_checks++; if (counter_out !== 32'(5 - k) || counter_OUT[0] !== 1'b0) begin
                n_fail++; $display("FAIL oneshot_cnt k=%0d: got cnt=%0h out=%b expected cnt=%0h out=0", k, counter_out, counter_OUT[0], 5 - k);
            end
        end
        step();
        n_checks++; if (counter_OUT[0] !== 1'b1 || counter_sts[0] !== 1'b1 || counter_out !== 32'h0) begin
            n_fail++; $display("FAIL oneshot_te: got out=%b sts=%b cnt=%0h expected 1 1 0", counter_OUT[0], counter_sts[0], counter_out);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++; if (counter_OUT[0] !== 1'b1 || counter_out !== 32'h0) begin
                n_fail++; $display("FAIL oneshot_hold: got out=%b cnt=%0h expected 1 0", counter_OUT[0], counter_out);
            end
        end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_masked: got %b expected 0", irq); end
        tick[0] = 1'b0;
        wr(4'hE, 32'h1);
        n_checks++; if (counter_sts !== 3'b000) begin n_fail++; $display("FAIL oneshot_clear: got %b expected 000", counter_sts); end
    endtask

    task automatic test_rate();
        counter_rd_ch = 3'd1;
        wr(4'hF, 32'hD0);
        wr(4'h1, 32'd3);
        tick[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_checks++; if (counter_out !== 32'(3 - (k % 4)) || counter_OUT[1] !== (k % 4 == 0)) begin
                n_fail++; $display("FAIL rate k=%0d: got cnt=%0h out=%b expected cnt=%0h out=%b", k, counter_out, counter_OUT[1], 3 - (k % 4), (k % 4 == 0));
            end
            if (k >= 4) begin
                n_checks++; if (irq !== (k >= 5)) begin n_fail++; $display("FAIL rate_irq k=%0d: got %b expected %b", k, irq, (k >= 5)); end
            end
        end
        wr(4'hE, 32'h2);
        n_checks++; if (counter_sts[1] !== 1'b0) begin n_fail++; $display("FAIL rate_clear: got %b expected 0", counter_sts[1]); end
        step();
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rate_irq_drop: got %b expected 0", irq); end
        step();
        wr(4'hE, 32'h2);
        n_checks++; if (counter_sts[1] !== 1'b1 || counter_OUT[1] !== 1'b1) begin
            n_fail++; $display("FAIL rate_set_beats_clear: got sts=%b out=%b expected 1 1", counter_sts[1], counter_OUT[1]);
        end
        tick[1] = 1'b0;
    endtask

    task automatic test_square();
        int exp_cnt [15] = '{5, 4, 3, 2, 1, 0, 3, 2, 1, 0, 3, 2, 1, 0, 3};
        logic exp_out [15] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
        logic exp_sts [15] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1};
        counter_rd_ch = 3'd2;
        wr(4'hF, 32'h600);
        wr(4'h2, 32'd6);
        for (int t = 1; t <= 15; t++) begin
            tick[2] = 1'b1;
            step();
            tick[2] = 1'b0;
            n_checks++; if (counter_out !== 32'(exp_cnt[t-1]) || counter_OUT[2] !== exp_out[t-1] || counter_sts[2] !== exp_sts[t-1]) begin
                n_fail++; $display("FAIL square t=%0d: got cnt=%0h out=%b sts=%b expected cnt=%0h out=%b sts=%b",
                                   t, counter_out, counter_OUT[2], counter_sts[2], exp_cnt[t-1], exp_out[t-1], exp_sts[t-1]);
            end
            if (t == 8) wr(4'hE, 32'h4);
            else step();
            n_checks++; if (counter_out !== 32'(exp_cnt[t-1])) begin
                n_fail++; $display("FAIL square_idle t=%0d: got %0h expected %0h", t, counter_out, exp_cnt[t-1]);
            end
        end
    endtask

    task automatic test_freerun();
        counter_rd_ch = 3'd0;
        wr(4'hF, 32'h7);
        wr(4'h0, 32'd1);
        tick[0] = 1'b1;
        step();
        n_checks++; if (counter_out !== 32'h0 || counter_OUT[0] !== 1'b0) begin n_fail++; $display("FAIL free_zero: got cnt=%0h out=%b expected 0 0", counter_out, counter_OUT[0]); end
        step();
        n_checks++; if (counter_out !== 32'hFF || counter_OUT[0] !== 1'b1 || counter_sts[0] !== 1'b1) begin
            n_fail++; $display("FAIL free_wrap: got cnt=%0h out=%b sts=%b expected ff 1 1", counter_out, counter_OUT[0], counter_sts[0]);
        end
        step();
        n_checks++; if (counter_out !== 32'hFE || counter_OUT[0] !== 1'b0) begin n_fail++; $display("FAIL free_after: got cnt=%0h out=%b expected fe 0", counter_out, counter_OUT[0]); end
        tick[0] = 1'b0;
        wr(4'hF, 32'h3);
        tick[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++; if (counter_out !== 32'hFE) begin n_fail++; $display("FAIL free_disabled: got %0h expected fe", counter_out); end
        end
        tick[0] = 1'b0;
    endtask

    task automatic test_collisions();
        counter_rd_ch = 3'd0;
        wr(4'hF, 32'h7);
        tick[0] = 1'b1;
        wr(4'h0, 32'h42);
        n_checks++; if (counter_out !== 32'h42) begin n_fail++; $display("FAIL coll_load_tick: got %0h expected 42", counter_out); end
        step();
        n_checks++; if (counter_out !== 32'h41) begin n_fail++; $display("FAIL coll_next_tick: got %0h expected 41", counter_out); end
        tick[0] = 1'b0;
        wr(4'h0, 32'h1234);
        n_checks++; if (counter_out !== 32'h34) begin n_fail++; $display("FAIL coll_trunc: got %0h expected 34", counter_out); end
        wr(4'h5, 32'hAA);
        n_checks++; if (counter_out !== 32'h34) begin n_fail++; $display("FAIL coll_addr5_ch0: got %0h expected 34", counter_out); end
        counter_rd_ch = 3'd1; #1;
        n_checks++; if (counter_out !== 32'h3) begin n_fail++; $display("FAIL coll_addr5_ch1: got %0h expected 3", counter_out); end
        counter_rd_ch = 3'd2; #1;
        n_checks++; if (counter_out !== 32'h3) begin n_fail++; $display("FAIL coll_addr5_ch2: got %0h expected 3", counter_out); end
        n_checks++; if (counter_OUT !== 3'b000 || counter_sts !== 3'b111 || irq !== 1'b0) begin
            n_fail++; $display("FAIL coll_addr5_flags: got out=%b sts=%b irq=%b expected 000 111 0", counter_OUT, counter_sts, irq);
        end
        counter_rd_ch = 3'd6; #1;
        n_checks++; if (counter_out !== 32'h0) begin n_fail++; $display("FAIL coll_rd6: got %0h expected 0", counter_out); end
        counter_rd_ch = 3'd3; #1;
        n_checks++; if (counter_out !== 32'h0) begin n_fail++; $display("FAIL coll_rd3: got %0h expected 0", counter_out); end
        counter_rd_ch = 3'd0;
        tick[0] = 1'b1;
        step();
        tick[0] = 1'b0;
        n_checks++; if (counter_out !== 32'h33) begin n_fail++; $display("FAIL coll_ctrl_kept: got %0h expected 33", counter_out); end
    endtask

    task automatic test_back_to_back();
        counter_rd_ch = 3'd1;
        wr(4'hF, 32'h50);
        wr(4'h1, 32'h0);
        tick[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++; if (counter_OUT[1] !== 1'b1 || counter_out !== 32'h0) begin
                n_fail++; $display("FAIL b2b k=%0d: got out=%b cnt=%0h expected 1 0", k, counter_OUT[1], counter_out);
            end
        end
        tick[1] = 1'b0;
        step();
        n_checks++; if (counter_OUT[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b expected 0", counter_OUT[1]); end
    endtask

    task automatic test_reset_mid();
        wr(4'hF, 32'hF7);
        tick[0] = 1'b1;
        step();
        step();
        step();
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b expected 1", irq); end
        rst = 1'b0;
        #1;
        n_checks++; if (counter_OUT !== 3'b000 || counter_sts !== 3'b000 || irq !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_flags: got out=%b sts=%b irq=%b expected 000 000 0", counter_OUT, counter_sts, irq);
        end
        for (int r = 0; r < 8; r++) begin
            counter_rd_ch = 3'(r);
            #1;
            n_checks++; if (counter_out !== 32'h0) begin n_fail++; $display("FAIL mid_reset_cnt rd=%0d: got %0h expected 0", r, counter_out); end
        end
        tick[0] = 1'b0;
        step();
        rst = 1'b1;
        $display("mid-count reset applied");
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_rate();
        test_square();
        test_freerun();
        test_collisions();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/counter_timer_n.md
# counter_timer_n

Parametrised N-channel down-counter/timer, successor to the fixed 3-channel counter in the IO polling subsystem. All channels run in the single `clk` domain and advance on per-channel `tick` enables, replacing per-channel clocks. Adds per-channel enable, a readback mux for any channel, sticky status flags with write-1-to-clear, and a maskable interrupt. Sits on the CPU IO bus next to the GPIO/polling logic.

## Interface
- `NCH`, 3: channel count, 1..8.
- `WIDTH`, 32: counter width, 2..32.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `tick` in NCH: per-channel count enable, one-`clk` pulses synchronous to `clk`.
- `counter_we` in 1: write strobe.
- `counter_ch` in 4: write address. 0..NCH-1 is the load register of channel n. 4'hE is status clear, write-1-to-clear on bits [NCH-1:0]. 4'hF is the control register. Other addresses are ignored.
- `counter_val` in 32: write data.
- `counter_rd_ch` in 3: readback channel select.
- `counter_out` out 32: count of the selected channel, zero-extended. Reads 0 if the selected channel is ≥ NCH. Combinational.
- `counter_OUT` out NCH: per-channel output signal, registered.
- `counter_sts` out NCH: sticky terminal-event flags.
- `irq` out 1: registered. Equals OR over n of sts[n] & ie[n].

## Operation
- Control register is 4 bits per channel at `counter_val[4n+3:4n]`: {ie, en, mode[1:0]}. Bits above 4*NCH are ignored.
- Per-channel state:
  - cnt: WIDTH bits.
  - load: WIDTH bits, taken from `counter_val[WIDTH-1:0]`.
  - out bit.
  - run flag.
  - sts bit.
- Load write (`counter_we`, addr n):
  - load ← val, cnt ← val, out ← 0, run ← 1, all in the next clk edge.
  - A tick in the same cycle is ignored.
- A channel advances only when `tick[n]` & en & run are all set. Otherwise it holds.
- One terminal event ("TE") occurs when the channel advances with cnt == 0.
- Mode 00, one-shot:
  - Advance with cnt ≠ 0: cnt−1.
  - At TE: out ← 1 and held, run ← 0, cnt stays 0, sts ← 1.
  - Re-arm only by a load write.
- Mode 01, rate generator:
  - Advance with cnt ≠ 0: cnt−1, out ← 0.
  - At TE: cnt ← load, out ← 1 for exactly one clk cycle, sts ← 1.
  - Period is load+1 ticks.
- Mode 10, square wave:
  - Advance with cnt ≠ 0: cnt−1.
  - At TE: cnt ← load>>1 and out toggles. sts ← 1 only when out goes 0→1.
  - Half-period is (load>>1)+1 ticks.
  - load of 0 or 1 toggles on every tick.
- Mode 11, free-run:
  - cnt−1 on every advance, wrapping 0 → 2^WIDTH−1.
  - At TE (the wrap): out pulses for one cycle, sts ← 1.
  - run is forced to 1 by a mode write to 11.
- Control write:
  - ctrl updates next edge.
  - For every channel whose mode field changes: out ← 0.
  - Mode change does not reload cnt.
  - A mode change into 00 with cnt == 0 leaves run unchanged.
- Status:
  - A clear write clears sts bits where `counter_val` has a 1.
  - Set has priority over clear for the same bit in the same cycle.
- Reset values, all asynchronous on `rst` low:
  - cnt, load, ctrl, out, run, sts all 0.
  - `irq` is 0.
  - `counter_OUT` is 0.
  - `counter_out` is 0.
  - After reset every channel is one-shot, disabled and idle.
- Reset mid-count aborts immediately. No event is generated.

## Timing
- Write-to-effect latency is 1 clk: the register value is visible on the edge that samples `counter_we`.
- Tick-to-count latency is 1 clk: cnt shows the decremented value after the edge sampling `tick`.
- TE updates out, sts and cnt on that same edge.
- `irq` follows sts/ie with one further clk of latency.
- `counter_out` follows `counter_rd_ch` and cnt combinationally, with no added latency.
- Pulse outputs (modes 01, 11) are high for exactly 1 clk, independent of tick spacing.
- Consecutive TEs in back-to-back cycles are legal: load 0 in mode 01 with tick held high pulses out every cycle.
- Arithmetic is modulo 2^WIDTH. `counter_val` bits above WIDTH are dropped on load.

## Test plan
- **Reset:** assert `rst`=0 mid-count in mode 11 → all outputs 0 within the same cycle, `counter_out`=0 for every `counter_rd_ch`.
- **One-shot:** NCH=3, WIDTH=8. Write ctrl 0x4 (ch0 en, mode 00), write load0=5, tick every cycle → cnt reads 5,4,3,2,1,0. On the 6th tick `counter_OUT[0]`=1 and `counter_sts[0]`=1. It stays high with no further change until the next load write.
- **Rate generator:** ch1 mode 01 en ie, ctrl 0xD0, load1=3, tick continuous → `counter_OUT[1]` 1-cycle pulse every 4 cycles. `irq` is asserted 1 cycle after the first pulse. Writing 4'hE with val 0x2 clears sts[1]; if a TE coincides with that write, sts[1] stays 1.
- **Square wave:** ch2 mode 10 en, load2=6, tick every other cycle → out toggles every 4 ticks (8 clk). sts[2] is set only on rising edges.
- **Free-run wrap, WIDTH=4:** load 1, tick ×2 → cnt 1,0 then 15 with a 1-cycle out pulse. Clearing en freezes cnt at its current value despite ticks.
- **Collisions:** load write coincident with tick → cnt equals the written value, not value−1. Write to address 4'h5 with NCH=3 → no state change. `counter_rd_ch`=6 → `counter_out`=0.
